// File: rtl/decoder_arb_pkg.sv
// Shared types and the rotating priority search for the decoder round-robin arbiter.
package decoder_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } winner_t;

    // Scans start, start+1, ... (mod NUM_REQ). Walking backwards lets the
    // smallest offset overwrite the others, so the nearest requester wins.
    function automatic winner_t next_winner(input logic [NUM_REQ-1:0] req,
                                            input logic [SEL_W-1:0]   start);
        winner_t          w;
        logic [SEL_W-1:0] k;
        w = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = start + SEL_W'(i);
            if (req[k]) begin
                w.found = 1'b1;
                w.idx   = k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Plain 2-to-4 decoder with enable; forms the one-hot grant from A and E.
module decoder_2to4
    import decoder_arb_pkg::*;
(
    input  logic [SEL_W-1:0]   A,
    input  logic               E,
    output logic [NUM_REQ-1:0] Y
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign Y[gi] = E & (A == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter driving a 2-to-4 decoder, with HOLD_MAX grant limit.
// Define DECODER_ARB_FIXED_PRIORITY_EN to search from index 0 instead of round-robin.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter  int HOLD_MAX = 8,
    localparam int CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   A,
    output logic               E,
    output logic [NUM_REQ-1:0] Y,
    output logic               rotate
);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   a_q, a_d, last_q, last_d, start;
    logic               e_q, e_d, rotate_q, rotate_d;
    logic [CW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] others;
    winner_t            win_any, win_oth;

`ifdef DECODER_ARB_FIXED_PRIORITY_EN
    assign start = '0;
`else
    assign start = last_q + 1'b1;
`endif

    assign others  = req & ~(NUM_REQ'(1) << a_q);
    assign win_any = next_winner(req, start);
    assign win_oth = next_winner(others, start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The grant is only dropped when the grantee releases and nobody else waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != '0) state_d = GRANT;
            GRANT:   if (req == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        e_d      = (state_d == GRANT);
        hold_d   = hold_q;
        last_d   = last_q;
        rotate_d = 1'b0;
        if (state_q == IDLE) begin
            if (win_any.found) begin
                a_d    = win_any.idx;
                hold_d = CW'(1);
                last_d = win_any.idx;
            end
        end else if (!req[a_q]) begin
            // Release; req[a_q] is already clear so win_any never picks a_q.
            if (win_any.found) begin
                a_d    = win_any.idx;
                hold_d = CW'(1);
                last_d = win_any.idx;
            end
        end else if (hold_q == CW'(HOLD_MAX)) begin
            hold_d = CW'(1);
            if (win_oth.found) begin
                a_d      = win_oth.idx;
                last_d   = win_oth.idx;
                rotate_d = 1'b1;
            end
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            e_q      <= 1'b0;
            hold_q   <= '0;
            last_q   <= SEL_W'(NUM_REQ - 1);
            rotate_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            e_q      <= e_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            rotate_q <= rotate_d;
        end
    end

    assign A      = a_q;
    assign E      = e_q;
    assign rotate = rotate_q;

    decoder_2to4 u_dec (
        .A (a_q),
        .E (e_q),
        .Y (Y)
    );

endmodule
